mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and ZBT memory signals of the frame-buffer arbiter.
// slave is the arbiter side, master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int LOG_ADDR = 19,
    parameter int LOG_MEM  = 36
);
    logic                vga_flag;
    logic [LOG_ADDR-1:0] vga_addr;
    logic [LOG_MEM-1:0]  vga_pixel;
    logic                done_vga;

    logic                ntsc_flag;
    logic [LOG_ADDR-1:0] ntsc_addr;
    logic [LOG_MEM-1:0]  ntsc_data;
    logic                done_ntsc;

    logic                proc_flag;
    logic                proc_we;
    logic [LOG_ADDR-1:0] proc_addr;
    logic [LOG_MEM-1:0]  proc_wdata;
    logic [LOG_MEM-1:0]  proc_rdata;
    logic                done_proc;

    logic [LOG_ADDR-1:0] mem_addr;
    logic                mem_we;
    logic [LOG_MEM-1:0]  mem_wdata;
    logic [LOG_MEM-1:0]  mem_rdata;
    logic                overflow;

    modport slave (
        input  vga_flag, vga_addr, ntsc_flag, ntsc_addr, ntsc_data,
               proc_flag, proc_we, proc_addr, proc_wdata, mem_rdata,
        output vga_pixel, done_vga, done_ntsc, proc_rdata, done_proc,
               mem_addr, mem_we, mem_wdata, overflow
    );

    modport master (
        output vga_flag, vga_addr, ntsc_flag, ntsc_addr, ntsc_data,
               proc_flag, proc_we, proc_addr, proc_wdata, mem_rdata,
        input  vga_pixel, done_vga, done_ntsc, proc_rdata, done_proc,
               mem_addr, mem_we, mem_wdata, overflow
    );
endinterface

// File: rtl/mem_arbiter.sv
// ZBT frame-buffer arbiter: VGA reads bypass with absolute priority, NTSC and
// PROC share the remaining slots round-robin through one-deep pending slots.
module mem_arbiter #(
    parameter int LOG_ADDR = 19,
    parameter int LOG_MEM  = 36
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_PROC = 2'd2
    } tag_t;

    logic                r_ntsc_pend;
    logic [LOG_ADDR-1:0] r_ntsc_addr;
    logic [LOG_MEM-1:0]  r_ntsc_data;
    logic                r_proc_pend;
    logic                r_proc_we;
    logic [LOG_ADDR-1:0] r_proc_addr;
    logic [LOG_MEM-1:0]  r_proc_data;
    logic                r_last_proc;

    tag_t                r_tag [3];
    logic [1:0]          r_wr_vld;
    logic [LOG_MEM-1:0]  r_wr_data [2];
    logic                r_ntsc_issued;
    logic                r_pwr_issued;

    logic [LOG_ADDR-1:0] r_mem_addr;
    logic                r_mem_we;
    logic [LOG_MEM-1:0]  r_mem_wdata;
    logic [LOG_MEM-1:0]  r_vga_pixel;
    logic [LOG_MEM-1:0]  r_proc_rdata;
    logic                r_done_vga;
    logic                r_done_ntsc;
    logic                r_done_proc;
    logic                r_overflow;

    logic                w_ntsc_req;
    logic [LOG_ADDR-1:0] w_ntsc_addr;
    logic [LOG_MEM-1:0]  w_ntsc_data;
    logic                w_proc_req;
    logic                w_proc_we;
    logic [LOG_ADDR-1:0] w_proc_addr;
    logic [LOG_MEM-1:0]  w_proc_data;
    logic                w_grant_ntsc;
    logic                w_grant_proc;

    // A fresh flag with an empty slot can be granted in the same cycle it arrives.
    assign w_ntsc_req  = r_ntsc_pend | bus.ntsc_flag;
    assign w_ntsc_addr = r_ntsc_pend ? r_ntsc_addr : bus.ntsc_addr;
    assign w_ntsc_data = r_ntsc_pend ? r_ntsc_data : bus.ntsc_data;
    assign w_proc_req  = r_proc_pend | bus.proc_flag;
    assign w_proc_we   = r_proc_pend ? r_proc_we   : bus.proc_we;
    assign w_proc_addr = r_proc_pend ? r_proc_addr : bus.proc_addr;
    assign w_proc_data = r_proc_pend ? r_proc_data : bus.proc_wdata;

    assign w_grant_ntsc = ~bus.vga_flag & w_ntsc_req & (~w_proc_req | r_last_proc);
    assign w_grant_proc = ~bus.vga_flag & w_proc_req & (~w_ntsc_req | ~r_last_proc);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ntsc_pend   <= 1'b0;
            r_ntsc_addr   <= '0;
            r_ntsc_data   <= '0;
            r_proc_pend   <= 1'b0;
            r_proc_we     <= 1'b0;
            r_proc_addr   <= '0;
            r_proc_data   <= '0;
            r_last_proc   <= 1'b1;
            for (int i = 0; i < 3; i++) r_tag[i] <= TAG_NONE;
            r_wr_vld      <= '0;
            r_wr_data[0]  <= '0;
            r_wr_data[1]  <= '0;
            r_ntsc_issued <= 1'b0;
            r_pwr_issued  <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_vga_pixel   <= '0;
            r_proc_rdata  <= '0;
            r_done_vga    <= 1'b0;
            r_done_ntsc   <= 1'b0;
            r_done_proc   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            // Capture when the slot is free and not consumed now, or is being consumed now.
            if (bus.ntsc_flag && (r_ntsc_pend == w_grant_ntsc)) begin
                r_ntsc_addr <= bus.ntsc_addr;
                r_ntsc_data <= bus.ntsc_data;
            end
            r_ntsc_pend <= w_grant_ntsc ? (r_ntsc_pend & bus.ntsc_flag)
                                        : (r_ntsc_pend | bus.ntsc_flag);
            if (bus.proc_flag && (r_proc_pend == w_grant_proc)) begin
                r_proc_we   <= bus.proc_we;
                r_proc_addr <= bus.proc_addr;
                r_proc_data <= bus.proc_wdata;
            end
            r_proc_pend <= w_grant_proc ? (r_proc_pend & bus.proc_flag)
                                        : (r_proc_pend | bus.proc_flag);
            if ((r_ntsc_pend & bus.ntsc_flag & ~w_grant_ntsc) |
                (r_proc_pend & bus.proc_flag & ~w_grant_proc))
                r_overflow <= 1'b1;

            r_mem_we      <= 1'b0;
            r_tag[0]      <= TAG_NONE;
            r_wr_vld[0]   <= 1'b0;
            r_ntsc_issued <= 1'b0;
            r_pwr_issued  <= 1'b0;
            if (bus.vga_flag) begin
                r_mem_addr <= bus.vga_addr;
                r_tag[0]   <= TAG_VGA;
            end else if (w_grant_ntsc) begin
                r_mem_addr    <= w_ntsc_addr;
                r_mem_we      <= 1'b1;
                r_wr_vld[0]   <= 1'b1;
                r_wr_data[0]  <= w_ntsc_data;
                r_ntsc_issued <= 1'b1;
                r_last_proc   <= 1'b0;
            end else if (w_grant_proc) begin
                r_mem_addr   <= w_proc_addr;
                r_mem_we     <= w_proc_we;
                r_wr_vld[0]  <= w_proc_we;
                r_wr_data[0] <= w_proc_data;
                r_tag[0]     <= w_proc_we ? TAG_NONE : TAG_PROC;
                r_pwr_issued <= w_proc_we;
                r_last_proc  <= 1'b1;
            end

            // ZBT: write data trails its address by two cycles, read data arrives two cycles later.
            r_tag[1]     <= r_tag[0];
            r_tag[2]     <= r_tag[1];
            r_wr_vld[1]  <= r_wr_vld[0];
            r_wr_data[1] <= r_wr_data[0];
            if (r_wr_vld[1])
                r_mem_wdata <= r_wr_data[1];

            r_done_ntsc <= r_ntsc_issued;
            r_done_vga  <= (r_tag[2] == TAG_VGA);
            r_done_proc <= r_pwr_issued | (r_tag[2] == TAG_PROC);
            if (r_tag[2] == TAG_VGA)
                r_vga_pixel <= bus.mem_rdata;
            if (r_tag[2] == TAG_PROC)
                r_proc_rdata <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.vga_pixel  = r_vga_pixel;
    assign bus.proc_rdata = r_proc_rdata;
    assign bus.done_vga   = r_done_vga;
    assign bus.done_ntsc  = r_done_ntsc;
    assign bus.done_proc  = r_done_proc;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: request-queue reference model scheduling expected
// output events by cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;
    localparam int LA = 19;
    localparam int LM = 36;
    localparam int N  = 8192;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if #(.LOG_ADDR(LA), .LOG_MEM(LM)) bus ();

    mem_arbiter #(.LOG_ADDR(LA), .LOG_MEM(LM)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [LM-1:0] mem_val(input logic [LA-1:0] a);
        return (a == 19'h00100) ? 36'h123456789 : {a[16:0], ~a};
    endfunction

    // ZBT memory: data for the address seen in cycle c appears in cycle c+2.
    logic [LA-1:0] a1 = '0;
    logic [LA-1:0] a2 = '0;
    always @(posedge clock) begin
        a1 <= bus.mem_addr;
        a2 <= a1;
    end
    assign bus.mem_rdata = mem_val(a2);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int c, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, got, exp);
        end
    endtask

    // Expected events, indexed by the cycle in which they become visible.
    bit            ev_rst [N];
    bit            ev_av  [N];
    bit [LA-1:0]   ev_addr[N];
    bit            ev_we  [N];
    bit            ev_wdv [N];
    bit [LM-1:0]   ev_wd  [N];
    bit            ev_dn  [N];
    bit            ev_dp  [N];
    bit            ev_vv  [N];
    bit [LM-1:0]   ev_vd  [N];
    bit            ev_pv  [N];
    bit [LM-1:0]   ev_pd  [N];
    bit            ev_ovf [N];

    bit [LA-1:0]   lg_addr[N];
    bit            lg_we  [N];
    bit [LM-1:0]   lg_wd  [N];
    bit            lg_dv  [N];
    bit [LM-1:0]   lg_pix [N];
    bit            lg_dn  [N];
    bit            lg_dp  [N];
    bit [LM-1:0]   lg_prd [N];
    bit            lg_ovf [N];

    typedef struct packed {
        logic          we;
        logic [LA-1:0] addr;
        logic [LM-1:0] data;
    } req_t;

    req_t nq[$];
    req_t pq[$];
    bit   last_proc = 1'b1;

    bit [LA-1:0] e_addr;
    bit [LM-1:0] e_wd, e_pix, e_prd;
    bit          e_ovf;
    bit          armed = 1'b0;

    initial begin
        forever begin
            int c;
            int w;
            req_t r;
            @(negedge clock);
            c = cyc;
            if (c < N - 8) begin
                if (ev_rst[c]) begin
                    e_addr = '0; e_wd = '0; e_pix = '0; e_prd = '0; e_ovf = 1'b0;
                    armed = 1'b1;
                end
                if (ev_av[c])  e_addr = ev_addr[c];
                if (ev_wdv[c]) e_wd   = ev_wd[c];
                if (ev_vv[c])  e_pix  = ev_vd[c];
                if (ev_pv[c])  e_prd  = ev_pd[c];
                if (ev_ovf[c]) e_ovf  = 1'b1;

                lg_addr[c] = bus.mem_addr;   lg_we[c] = bus.mem_we;
                lg_wd[c]   = bus.mem_wdata;  lg_dv[c] = bus.done_vga;
                lg_pix[c]  = bus.vga_pixel;  lg_dn[c] = bus.done_ntsc;
                lg_dp[c]   = bus.done_proc;  lg_prd[c] = bus.proc_rdata;
                lg_ovf[c]  = bus.overflow;

                if (armed) begin
                    chk("mem_addr",   c, 64'(bus.mem_addr),   64'(e_addr));
                    chk("mem_we",     c, 64'(bus.mem_we),     64'(ev_av[c] & ev_we[c]));
                    chk("mem_wdata",  c, 64'(bus.mem_wdata),  64'(e_wd));
                    chk("done_vga",   c, 64'(bus.done_vga),   64'(ev_vv[c]));
                    chk("vga_pixel",  c, 64'(bus.vga_pixel),  64'(e_pix));
                    chk("done_ntsc",  c, 64'(bus.done_ntsc),  64'(ev_dn[c]));
                    chk("done_proc",  c, 64'(bus.done_proc),  64'(ev_dp[c]));
                    chk("proc_rdata", c, 64'(bus.proc_rdata), 64'(e_prd));
                    chk("overflow",   c, 64'(bus.overflow),   64'(e_ovf));
                end

                if (reset) begin
                    for (int k = c + 1; k <= c + 5; k++) begin
                        ev_av[k] = 0; ev_wdv[k] = 0; ev_dn[k] = 0; ev_dp[k] = 0;
                        ev_vv[k] = 0; ev_pv[k] = 0; ev_ovf[k] = 0; ev_we[k] = 0;
                    end
                    ev_rst[c+1] = 1'b1;
                    nq.delete();
                    pq.delete();
                    last_proc = 1'b1;
                end else begin
                    if (bus.ntsc_flag) nq.push_back('{1'b1, bus.ntsc_addr, bus.ntsc_data});
                    if (bus.proc_flag) pq.push_back('{bus.proc_we, bus.proc_addr, bus.proc_wdata});
                    w = 0;
                    if (bus.vga_flag)                        w = 1;
                    else if (nq.size() > 0 && pq.size() > 0) w = last_proc ? 2 : 3;
                    else if (nq.size() > 0)                  w = 2;
                    else if (pq.size() > 0)                  w = 3;
                    if (w == 1) begin
                        ev_av[c+1] = 1; ev_addr[c+1] = bus.vga_addr; ev_we[c+1] = 0;
                        ev_vv[c+4] = 1; ev_vd[c+4] = mem_val(bus.vga_addr);
                    end else if (w != 0) begin
                        if (w == 2) begin
                            r = nq.pop_front();
                            last_proc = 1'b0;
                            ev_dn[c+2] = 1;
                        end else begin
                            r = pq.pop_front();
                            last_proc = 1'b1;
                        end
                        ev_av[c+1] = 1; ev_addr[c+1] = r.addr; ev_we[c+1] = r.we;
                        if (r.we) begin
                            ev_wdv[c+3] = 1; ev_wd[c+3] = r.data;
                            if (w == 3) ev_dp[c+2] = 1;
                        end else begin
                            ev_pv[c+4] = 1; ev_pd[c+4] = mem_val(r.addr); ev_dp[c+4] = 1;
                        end
                    end
                    if (nq.size() > 1) begin void'(nq.pop_back()); ev_ovf[c+1] = 1; end
                    if (pq.size() > 1) begin void'(pq.pop_back()); ev_ovf[c+1] = 1; end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.vga_flag = 0; bus.ntsc_flag = 0; bus.proc_flag = 0; bus.proc_we = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nwe;
        logic [63:0] rnd;
        idle();
        bus.vga_addr = '0; bus.ntsc_addr = '0; bus.ntsc_data = '0;
        bus.proc_addr = '0; bus.proc_wdata = '0;
        repeat (2) tick();

        // VGA read latency
        do_reset(); t0 = cyc;
        bus.vga_flag = 1; bus.vga_addr = 19'h00100;
        tick(); idle(); repeat (6) tick();
        chk("vga_rd_addr", t0 + 1, 64'(lg_addr[t0+1]), 64'h00100);
        chk("vga_done_early", t0 + 3, 64'(lg_dv[t0+3]), 64'd0);
        chk("vga_done", t0 + 4, 64'(lg_dv[t0+4]), 64'd1);
        chk("vga_pixel_val", t0 + 4, 64'(lg_pix[t0+4]), 64'h123456789);
        chk("vga_done_late", t0 + 5, 64'(lg_dv[t0+5]), 64'd0);

        // Three-way contention
        do_reset(); t0 = cyc;
        bus.vga_flag = 1; bus.vga_addr = 19'h00010;
        bus.ntsc_flag = 1; bus.ntsc_addr = 19'h00020; bus.ntsc_data = 36'h111;
        bus.proc_flag = 1; bus.proc_we = 0; bus.proc_addr = 19'h00030;
        tick(); idle(); repeat (7) tick();
        chk("cont_vga_addr", t0 + 1, 64'(lg_addr[t0+1]), 64'h10);
        chk("cont_ntsc_addr", t0 + 2, 64'(lg_addr[t0+2]), 64'h20);
        chk("cont_ntsc_we", t0 + 2, 64'(lg_we[t0+2]), 64'd1);
        chk("cont_proc_addr", t0 + 3, 64'(lg_addr[t0+3]), 64'h30);
        chk("cont_proc_we", t0 + 3, 64'(lg_we[t0+3]), 64'd0);
        chk("cont_done_ntsc", t0 + 3, 64'(lg_dn[t0+3]), 64'd1);
        chk("cont_done_proc", t0 + 6, 64'(lg_dp[t0+6]), 64'd1);
        chk("cont_proc_rdata", t0 + 6, 64'(lg_prd[t0+6]), 64'h00187FFCF);

        // Proc write timing at top address
        do_reset(); t0 = cyc;
        bus.proc_flag = 1; bus.proc_we = 1; bus.proc_addr = 19'h7FFFF; bus.proc_wdata = 36'hABCDE0123;
        tick(); idle(); repeat (5) tick();
        chk("wr_addr", t0 + 1, 64'(lg_addr[t0+1]), 64'h7FFFF);
        chk("wr_we", t0 + 1, 64'(lg_we[t0+1]), 64'd1);
        chk("wr_wdata_early", t0 + 2, 64'(lg_wd[t0+2]), 64'd0);
        chk("wr_wdata", t0 + 3, 64'(lg_wd[t0+3]), 64'hABCDE0123);
        chk("wr_done", t0 + 2, 64'(lg_dp[t0+2]), 64'd1);
        chk("wr_done_once", t0 + 3, 64'(lg_dp[t0+3]), 64'd0);

        // Round-robin under continuous demand
        do_reset(); t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            bus.ntsc_flag = 1; bus.ntsc_addr = 19'(32'h100 + i); bus.ntsc_data = 36'(i);
            bus.proc_flag = 1; bus.proc_we = 1; bus.proc_addr = 19'(32'h200 + i); bus.proc_wdata = 36'(i);
            tick();
        end
        idle(); repeat (4) tick();
        for (int k = 1; k <= 8; k++) begin
            chk("rr_owner", t0 + k, 64'(lg_addr[t0+k][9:8]), (k % 2 == 1) ? 64'd1 : 64'd2);
            chk("rr_we", t0 + k, 64'(lg_we[t0+k]), 64'd1);
        end

        // Overflow on NTSC re-request while pending behind VGA
        do_reset(); t0 = cyc;
        bus.vga_flag = 1; bus.vga_addr = 19'h40;
        bus.ntsc_flag = 1; bus.ntsc_addr = 19'h50; bus.ntsc_data = 36'h5;
        tick();
        bus.vga_addr = 19'h44; bus.ntsc_addr = 19'h51; bus.ntsc_data = 36'h6;
        tick(); idle(); repeat (6) tick();
        chk("ovf_before", t0 + 1, 64'(lg_ovf[t0+1]), 64'd0);
        chk("ovf_set", t0 + 2, 64'(lg_ovf[t0+2]), 64'd1);
        chk("ovf_sticky", t0 + 7, 64'(lg_ovf[t0+7]), 64'd1);
        chk("ovf_ntsc_addr", t0 + 3, 64'(lg_addr[t0+3]), 64'h50);
        chk("ovf_ntsc_data", t0 + 5, 64'(lg_wd[t0+5]), 64'h5);
        nwe = 0;
        for (int k = 1; k <= 7; k++) nwe += int'(lg_we[t0+k]);
        chk("ovf_one_write", t0, 64'(nwe), 64'd1);

        // Reset in the middle of a VGA read
        do_reset(); t0 = cyc;
        bus.vga_flag = 1; bus.vga_addr = 19'h00100;
        tick(); idle();
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        repeat (4) tick();
        for (int k = 0; k <= 6; k++)
            chk("rst_no_done_vga", t0 + k, 64'(lg_dv[t0+k]), 64'd0);
        for (int k = 3; k <= 5; k++)
            chk("rst_pixel_zero", t0 + k, 64'(lg_pix[t0+k]), 64'd0);

        // Randomized traffic against the model
        do_reset();
        repeat (2500) begin
            bus.vga_flag  = ($urandom_range(0, 4) == 0);
            bus.vga_addr  = 19'($urandom);
            bus.ntsc_flag = ($urandom_range(0, 2) == 0);
            bus.ntsc_addr = 19'($urandom);
            rnd = {$urandom, $urandom};
            bus.ntsc_data = rnd[35:0];
            bus.proc_flag = ($urandom_range(0, 2) == 0);
            bus.proc_we   = 1'($urandom);
            bus.proc_addr = 19'($urandom);
            rnd = {$urandom, $urandom};
            bus.proc_wdata = rnd[35:0];
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
